// File: rtl/fft4_seq_ctrl_pkg.sv
// Shared definitions for the 4-point FFT sequencer: state encoding, default
// sample width and the output-width derivation.
`ifndef FFT4_SEQ_CTRL_PKG_SV
`define FFT4_SEQ_CTRL_PKG_SV

// Full-range signed width for a 4-sample sum of DW-bit unsigned values.
`define FFT4_OW(dw) ((dw) + 3)

package fft4_seq_ctrl_pkg;

  localparam int DEF_DW = 2;

  typedef enum logic [1:0] {
    ST_LOAD    = 2'd0,
    ST_COMPUTE = 2'd1,
    ST_OUT     = 2'd2
  } state_t;

endpackage

`endif

// File: rtl/fft4_bfly.sv
// Combinational radix-2 butterfly network for a 4-point FFT of real
// unsigned samples; inputs are zero-extended to the signed output width.
module fft4_bfly #(
  parameter int DW = 2,
  parameter int OW = DW + 3
) (
  input  logic        [DW-1:0] i_x0,
  input  logic        [DW-1:0] i_x1,
  input  logic        [DW-1:0] i_x2,
  input  logic        [DW-1:0] i_x3,
  output logic signed [OW-1:0] o_x0_re,
  output logic signed [OW-1:0] o_x0_im,
  output logic signed [OW-1:0] o_x1_re,
  output logic signed [OW-1:0] o_x1_im,
  output logic signed [OW-1:0] o_x2_re,
  output logic signed [OW-1:0] o_x2_im,
  output logic signed [OW-1:0] o_x3_re,
  output logic signed [OW-1:0] o_x3_im
);

  logic signed [OW-1:0] w_a, w_b, w_c, w_d;
  logic signed [OW-1:0] w_s02, w_d02, w_s13, w_d13;

  assign w_a = {{(OW-DW){1'b0}}, i_x0};
  assign w_b = {{(OW-DW){1'b0}}, i_x1};
  assign w_c = {{(OW-DW){1'b0}}, i_x2};
  assign w_d = {{(OW-DW){1'b0}}, i_x3};

  assign w_s02 = w_a + w_c;
  assign w_d02 = w_a - w_c;
  assign w_s13 = w_b + w_d;
  assign w_d13 = w_b - w_d;

  assign o_x0_re = w_s02 + w_s13;
  assign o_x0_im = '0;
  assign o_x1_re = w_d02;
  assign o_x1_im = -w_d13;
  assign o_x2_re = w_s02 - w_s13;
  assign o_x2_im = '0;
  assign o_x3_re = w_d02;
  assign o_x3_im = w_d13;

endmodule

// File: rtl/fft4_seq_ctrl.sv
// Framed valid/ready sequencer around the 4-point FFT butterfly.
// FFT4_OVERLAP_EN: accept the next frame while the current bins stream out.
module fft4_seq_ctrl
  import fft4_seq_ctrl_pkg::*;
#(
  parameter  int DW = DEF_DW,
  localparam int OW = `FFT4_OW(DW)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic        [DW-1:0] in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic signed [OW-1:0] out_re,
  output logic signed [OW-1:0] out_im,
  output logic        [1:0]    out_idx,
  output logic                 out_last
);

  state_t               r_state, w_state_nxt;
  logic [2:0]           r_cnt, w_cnt_inc, w_cnt_nxt;
  logic [1:0]           r_bin;
  logic [3:0][DW-1:0]   r_samp;
  logic [3:0][OW-1:0]   r_re, r_im;
  logic [3:0][OW-1:0]   w_re, w_im;
  logic                 w_in_acc, w_out_acc;

  fft4_bfly #(.DW(DW), .OW(OW)) u_bfly (
    .i_x0    (r_samp[0]),
    .i_x1    (r_samp[1]),
    .i_x2    (r_samp[2]),
    .i_x3    (r_samp[3]),
    .o_x0_re (w_re[0]),
    .o_x0_im (w_im[0]),
    .o_x1_re (w_re[1]),
    .o_x1_im (w_im[1]),
    .o_x2_re (w_re[2]),
    .o_x2_im (w_im[2]),
    .o_x3_re (w_re[3]),
    .o_x3_im (w_im[3])
  );

`ifdef FFT4_OVERLAP_EN
  // Results are held in r_re/r_im, so the sample buffer is free during OUT.
  assign in_ready = (r_state == ST_LOAD) || ((r_state == ST_OUT) && (r_cnt < 3'd4));
`else
  assign in_ready = (r_state == ST_LOAD);
`endif
  assign out_valid = (r_state == ST_OUT);
  assign w_in_acc  = in_valid && in_ready;
  assign w_out_acc = out_valid && out_ready;
  assign w_cnt_inc = r_cnt + {2'b00, w_in_acc};

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_LOAD:    if (w_cnt_inc == 3'd4) w_state_nxt = ST_COMPUTE;
      ST_COMPUTE: w_state_nxt = ST_OUT;
      ST_OUT: begin
        if (w_out_acc && (r_bin == 2'd3)) begin
`ifdef FFT4_OVERLAP_EN
          w_state_nxt = (w_cnt_inc == 3'd4) ? ST_COMPUTE : ST_LOAD;
`else
          w_state_nxt = ST_LOAD;
`endif
        end
      end
      default:    w_state_nxt = ST_LOAD;
    endcase
  end

  // Any entry into COMPUTE consumes the full sample buffer.
  assign w_cnt_nxt = (w_state_nxt == ST_COMPUTE) ? 3'd0 : w_cnt_inc;

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= ST_LOAD;
    else        r_state <= w_state_nxt;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt  <= '0;
      r_bin  <= '0;
      r_samp <= '0;
      r_re   <= '0;
      r_im   <= '0;
    end else begin
      r_cnt <= w_cnt_nxt;
      if (w_in_acc) r_samp[r_cnt[1:0]] <= in_data;
      if (r_state == ST_COMPUTE) begin
        r_re  <= w_re;
        r_im  <= w_im;
        r_bin <= '0;
      end else if (w_out_acc) begin
        r_bin <= r_bin + 2'd1;
      end
    end
  end

  assign out_re   = r_re[r_bin];
  assign out_im   = r_im[r_bin];
  assign out_idx  = r_bin;
  assign out_last = out_valid && (r_bin == 2'd3);

endmodule

// File: tb/tb_fft4_seq_ctrl.sv
// Scoreboard bench for fft4_seq_ctrl: directed frames push hand-computed bins,
// a monitor pops and compares on every output handshake.
module tb_fft4_seq_ctrl;

  localparam int DW = 2;
  localparam int OW = DW + 3;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 in_valid;
  logic                 in_ready;
  logic        [DW-1:0] in_data;
  logic                 out_valid;
  logic                 out_ready;
  logic signed [OW-1:0] out_re;
  logic signed [OW-1:0] out_im;
  logic        [1:0]    out_idx;
  logic                 out_last;

  fft4_seq_ctrl #(.DW(DW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_re    (out_re),
    .out_im    (out_im),
    .out_idx   (out_idx),
    .out_last  (out_last)
  );

  always #5 clk = ~clk;

  typedef struct {
    int re;
    int im;
    int idx;
  } exp_t;

  exp_t q[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   stalls = 0;
  int   last_cyc[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic push_exp(input int r0, input int i0, input int r1, input int i1,
                          input int r2, input int i2, input int r3, input int i3);
    q.push_back('{r0, i0, 0});
    q.push_back('{r1, i1, 1});
    q.push_back('{r2, i2, 2});
    q.push_back('{r3, i3, 3});
  endtask

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send(input int d);
    bit done;
    done = 0;
    in_valid = 1'b1;
    in_data  = DW'(d);
    for (int k = 0; k < 100 && !done; k++) begin
      @(negedge clk);
      if (in_ready) done = 1;
      else          stalls++;
      @(posedge clk);
      #1;
    end
    if (!done) chk("send_timeout", 0, 1);
  endtask

  task automatic send4(input int a, input int b, input int c, input int d);
    send(a); send(b); send(c); send(d);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int k = 0; k < 200 && q.size() != 0; k++) @(negedge clk);
    chk("drain_left", q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid();
    bit seen;
    seen = 0;
    for (int k = 0; k < 50 && !seen; k++) begin
      @(negedge clk);
      seen = out_valid;
    end
    chk("wait_valid", int'(seen), 1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && out_valid && out_ready) begin
        if (q.size() == 0) begin
          chk("unexpected_bin", int'(out_idx), -1);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("bin_re", int'(out_re), e.re);
          chk("bin_im", int'(out_im), e.im);
          chk("bin_idx", int'(out_idx), e.idx);
          chk("bin_last", int'(out_last), int'(e.idx == 3));
          if (out_last) last_cyc.push_back(cyc);
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", int'(in_ready), 1);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_re", int'(out_re), 0);
    chk("rst_out_im", int'(out_im), 0);
    chk("rst_out_idx", int'(out_idx), 0);
    chk("rst_out_last", int'(out_last), 0);
    @(posedge clk); #1;

    // Basic frame and one-cycle compute latency.
    out_ready = 1'b1;
    push_exp(6, 0, -2, -2, 2, 0, -2, 2);
    send4(1, 2, 3, 0);
    @(negedge clk);
    chk("lat_compute_valid", int'(out_valid), 0);
    chk("lat_compute_ready", int'(in_ready), 0);
    @(negedge clk);
    chk("lat_out_valid", int'(out_valid), 1);
    drain();

    // Maximum input.
    push_exp(12, 0, 0, 0, 0, 0, 0, 0);
    send4(3, 3, 3, 3);
    drain();

    // Back-pressure on bin 1.
    out_ready = 1'b0;
    push_exp(6, 0, 2, 2, -2, 0, 2, -2);
    send4(2, 1, 0, 3);
    wait_valid();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
`ifndef FFT4_OVERLAP_EN
    in_valid = 1'b1;
    in_data  = 2'd3;
`endif
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("bp_valid", int'(out_valid), 1);
      chk("bp_idx", int'(out_idx), 1);
      chk("bp_re", int'(out_re), 2);
      chk("bp_im", int'(out_im), 2);
`ifndef FFT4_OVERLAP_EN
      chk("bp_in_ready", int'(in_ready), 0);
`endif
    end
    @(posedge clk); #1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    drain();

    // Gapped input: valid every other cycle.
    push_exp(6, 0, 2, 2, 2, 0, 2, -2);
    send(3); in_valid = 1'b0; in_data = 2'd1; @(posedge clk); #1;
    send(0); in_valid = 1'b0; in_data = 2'd3; @(posedge clk); #1;
    send(1); in_valid = 1'b0; in_data = 2'd3; @(posedge clk); #1;
    send(2); in_valid = 1'b0;
    drain();

    // Reset while bins are pending: they must never appear.
    out_ready = 1'b0;
    send4(1, 1, 1, 1);
    wait_valid();
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_mid_out_valid", int'(out_valid), 0);
    chk("rst_mid_out_re", int'(out_re), 0);
    chk("rst_mid_in_ready", int'(in_ready), 1);
    @(posedge clk); #1;
    out_ready = 1'b1;

    // Reset after two samples: stale samples discarded.
    send(3); send(3); in_valid = 1'b0;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    push_exp(2, 0, 0, 0, -2, 0, 0, 0);
    send4(0, 1, 0, 1);
    drain();

`ifdef FFT4_OVERLAP_EN
    // Back-to-back frames: one stall (COMPUTE) per following frame.
    last_cyc.delete();
    stalls = 0;
    push_exp(6, 0, -2, -2, 2, 0, -2, 2);
    push_exp(12, 0, 0, 0, 0, 0, 0, 0);
    push_exp(2, 0, 0, 0, -2, 0, 0, 0);
    send(1); send(2); send(3); send(0);
    send(3); send(3); send(3); send(3);
    send(0); send(1); send(0); send(1);
    in_valid = 1'b0;
    chk("ovl_stalls", stalls, 2);
    drain();
    chk("ovl_frames", last_cyc.size(), 3);
    if (last_cyc.size() == 3) begin
      chk("ovl_period_a", last_cyc[1] - last_cyc[0], 5);
      chk("ovl_period_b", last_cyc[2] - last_cyc[1], 5);
    end
`endif

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got %0d vectors, expected completion", n_vec);
    $fatal(1, "timeout");
  end

endmodule
